// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file access sequencer: op codes,
// register index width and the controller state encoding.
package cpu_pkg;

    localparam int          REG_IDX_W = 5;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_RD_OUT,
        ST_WR,
        ST_DONE
    } rac_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Debug/test sequencer for the regfile's synchronous port: dumps a window of
// registers onto a valid/ready stream, or loads a stream into consecutive registers.
module regfile_access_ctrl
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [4:0]           cmd_start,
    input  logic [5:0]           cmd_count,
    output logic [4:0]           rf_readReg,
    input  logic [DATAWIDTH-1:0] rf_readData,
    output logic [4:0]           rf_writeReg,
    output logic [DATAWIDTH-1:0] rf_writeData,
    output logic                 rf_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [4:0]           out_idx,
    output logic                 out_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 busy,
    output logic                 done
);

    if (NREGS != (1 << REG_IDX_W)) begin : g_bad_nregs
        $error("regfile_access_ctrl: NREGS must equal 2**REG_IDX_W");
    end

    rac_state_t           r_state;
    logic [4:0]           r_idx;
    logic [5:0]           r_rem;
    logic [4:0]           r_rd_reg;
    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_out_data;
    logic [4:0]           r_out_idx;
    logic                 r_out_last;

    logic                 w_wr_hs;
    logic                 w_wr_en;

    // x0 is hardwired zero: its load word is consumed without a write
    assign w_wr_hs = (r_state == ST_WR) && in_valid;
    assign w_wr_en = w_wr_hs && (r_idx != REG_ZERO);

    assign rf_write     = w_wr_en;
    assign rf_writeReg  = w_wr_en ? r_idx : '0;
    assign rf_writeData = w_wr_en ? in_data : '0;
    assign rf_readReg   = r_rd_reg;

    assign cmd_ready = (r_state == ST_IDLE);
    assign in_ready  = (r_state == ST_WR);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_rd_reg    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_idx <= cmd_start;
                        r_rem <= cmd_count;
                        if (cmd_count == 6'd0) begin
                            r_state <= ST_DONE;
                        end else if (cmd_op == OP_DUMP) begin
                            r_rd_reg <= cmd_start;
                            r_state  <= ST_RD_WAIT;
                        end else begin
                            r_state <= ST_WR;
                        end
                    end
                end
                ST_RD_WAIT: r_state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    r_out_data  <= rf_readData;
                    r_out_idx   <= r_idx;
                    r_out_last  <= (r_rem == 6'd1);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rem       <= r_rem - 6'd1;
                        if (r_out_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx    <= r_idx + 5'd1;
                            r_rd_reg <= r_idx + 5'd1;
                            r_state  <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR: begin
                    if (in_valid) begin
                        r_idx <= r_idx + 5'd1;
                        r_rem <= r_rem - 6'd1;
                        if (r_rem == 6'd1) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Initiator-side sequencer for the register file's synchronous read/write port, used by debug and test infrastructure.
- Dump: reads a window of registers and streams them out over a valid/ready interface, absorbing the regfile's one-cycle registered read latency.
- Load: accepts a valid/ready input stream and writes it into consecutive registers.
- Sits beside the CPU datapath and drives the regfile's readReg1/writeReg/writeData/write while the core is halted.

Parameters:
- DATAWIDTH, 32, register/data width; matches the regfile.
- NREGS, 32, number of architectural registers; index width fixed at 5.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = dump, 1 = load
- cmd_start  in  5  first register index
- cmd_count  in  6  number of registers, 0..32
- rf_readReg  out  5  to regfile readReg1
- rf_readData  in  DATAWIDTH  from regfile readData1
- rf_writeReg  out  5  to regfile writeReg
- rf_writeData  out  DATAWIDTH  to regfile writeData
- rf_write  out  1  regfile write enable
- out_valid  out  1  dump word available
- out_ready  in  1  sink accepts
- out_data  out  DATAWIDTH  register value
- out_idx  out  5  index of out_data
- out_last  out  1  final word of the command
- in_valid  in  1  load word offered
- in_ready  out  1  controller accepts load word
- in_data  in  DATAWIDTH  load word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 except cmd_ready=1. Regfile contents are not touched.
- Reset mid-command aborts it with no done pulse. A reset asserted while rf_write is high may drop that write.
- States: IDLE, RD_WAIT, RD_CAP, RD_OUT, WR, DONE.
- Acceptance: cmd_valid & cmd_ready at edge T latches op, idx=cmd_start, remaining=cmd_count.
  - cmd_count=0: go to DONE (no transfers, no regfile access).
  - Dump: rf_readReg<=cmd_start, go to RD_WAIT.
  - Load: go to WR.
- Dump sequence:
  - RD_WAIT: the regfile samples rf_readReg this edge; go to RD_CAP.
  - RD_CAP: rf_readData is valid; at the edge, out_data<=rf_readData, out_idx<=idx, out_last<=(remaining==1), out_valid<=1; go to RD_OUT.
  - RD_OUT: hold out_data, out_idx, out_last stable while out_valid & !out_ready.
  - On handshake: out_valid<=0, remaining-1. If last, go to DONE; else idx+1, rf_readReg<=idx+1, go to RD_WAIT.
  - Timing: first out_valid is high in cycle T+3. Steady state is 3 cycles per word with out_ready held high.
  - rf_write stays 0 throughout dump, so the regfile's write bypass never alters read data.
- Load sequence (WR):
  - in_ready=1 combinationally while in WR.
  - On in_valid & in_ready: drive rf_writeReg=idx, rf_writeData=in_data, rf_write=1 for exactly that cycle (combinational from the handshake, registered into the regfile at the same edge); then idx+1, remaining-1.
  - Exception: idx==0 consumes the word with rf_write=0, so x0 stays zero.
  - After the last word, go to DONE. Throughput is 1 word/cycle.
- DONE: done=1 for one cycle, busy=1; next state IDLE.
- Index arithmetic is 5-bit modulo 32: cmd_start=30, count=4 visits 30, 31, 0, 1.
- The remaining counter is 6 bits, so count=32 is legal and visits every register exactly once.
- cmd_* inputs are ignored outside IDLE.
- in_valid is ignored outside WR; out_ready is ignored outside RD_OUT.

Decomposition:
- Shared package (cpu_pkg): state enum, op encodings (OP_DUMP=0, OP_LOAD=1), REG_IDX_W=5, REG_ZERO=0.
- No sub-module. The FSM and counters form a single module; the regfile is instantiated only by the bench and top.

Test Plan:
- Preload regfile x5=0xA5A5A5A5, x6=0x00000006; dump start=5 count=2, out_ready=1 -> out (idx 5, 0xA5A5A5A5, last 0), then (idx 6, 0x00000006, last 1). First out_valid at T+3; done pulses once.
- Dump start=30 count=4 with out_ready toggling 0/1 every cycle -> indices 30, 31, 0, 1 in order. Data is stable during stalls; no word lost or duplicated.
- Load start=31 count=3 with in_data 0x11, 0x22, 0x33 and in_valid bursty -> x31=0x11, x0 stays 0, x1=0x33. rf_write is seen exactly twice.
- cmd_count=0 (either op) -> done pulses the cycle after acceptance. No out_valid, no rf_write; cmd_ready=1 again the cycle after.
- Full dump count=32 after a load of value i+0x100 into xi -> 32 words; x0 reads 0, the rest read i+0x100; out_last only on idx 31 (start=0).
- Assert rst during RD_OUT with out_valid=1 -> out_valid, busy, and done drop immediately (before the next edge). cmd_ready=1; a new command is accepted normally after rst deasserts.
